multdiv_arbiter: RTL
====================

# multdiv_arbiter

Two-port scheduler that shares the single `multdiv` unit between two requesters, e.g. the execute stage and a microcode sequencer. It arbitrates round-robin, latches the winner's operands, issues a one-cycle `ctrl_MULT`/`ctrl_DIV` pulse, waits for `data_resultRDY` under a watchdog, and returns the result through a per-port valid/ready response handshake. It sits between the requesters and `multdiv`, and is the only driver of the `multdiv` inputs.

## Interface
- TIMEOUT, 64: max WAIT cycles before forced abort; legal range 2..255.
- clock  in  1  rising-edge clock, shared with `multdiv`.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  2  bit i: requester i has an operation pending.
- req_ready  out  2  bit i: request i accepted this cycle.
- req_op  in  2  bit i: 0 = multiply, 1 = divide, for requester i.
- req_a0, req_b0  in  32 each  operands A/B of requester 0.
- req_a1, req_b1  in  32 each  operands A/B of requester 1.
- rsp_valid  out  2  bit i: response for requester i is held.
- rsp_ready  in  2  bit i: requester i consumes its response.
- rsp_result  out  32  result (product, or quotient).
- rsp_exception  out  1  `multdiv` exception, or forced by timeout.
- rsp_timeout  out  1  response produced by the watchdog.
- md_operandA, md_operandB  out  32 each  to `multdiv` data_operandA/B.
- md_ctrl_MULT, md_ctrl_DIV  out  1 each  to `multdiv` ctrl_MULT/ctrl_DIV.
- md_result  in  32  from `multdiv` data_result.
- md_exception  in  1  from `multdiv` data_exception.
- md_resultRDY  in  1  from `multdiv` data_resultRDY.
- busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, START, WAIT, RESP. Registers: owner (1b), op (1b), opA/opB (32b each), rr pointer (1b), wdog (8b), result (32b), exc (1b), tmo (1b).
- IDLE:
  - Winner = the only valid port, or the port selected by rr when both are valid.
  - req_ready[winner] = 1 combinationally, in the same cycle.
  - At the edge: latch owner, op and operands; go to START.
  - With no request valid, stay in IDLE.
- START:
  - Pulse exactly one of md_ctrl_MULT/md_ctrl_DIV for one cycle, selected by op.
  - Clear wdog; go to WAIT.
  - md_resultRDY is ignored in this cycle.
- WAIT:
  - wdog increments each cycle.
  - When md_resultRDY = 1, capture md_result into result and md_exception into exc; tmo = 0; go to RESP.
  - When wdog = TIMEOUT-1 and RDY is still low: result = 0, exc = 1, tmo = 1; go to RESP.
  - When RDY and the timeout occur in the same cycle, RDY wins.
- RESP:
  - rsp_valid[owner] = 1; rsp_result, rsp_exception and rsp_timeout are driven from registers.
  - On rsp_ready[owner] = 1: go to IDLE and set rr to prefer the other port (!owner).
  - rsp_ready on the non-owner port is ignored.
- md_operandA/B = opA/opB at all times. They are stable from START until the next grant.
- md_ctrl_* are 0 outside START. Both are never high together.
- md_resultRDY and md_exception are ignored outside WAIT.
- The block performs no arithmetic. Result width and exception semantics are those of `multdiv`, passed through unchanged.
- Requesters must hold req_* stable while req_valid is high and unaccepted. Dropping req_valid before the grant is legal.

## Timing
- Reset (asynchronous, reset_n = 0):
  - State IDLE, rr = port 0, owner = 0, all registers 0.
  - Outputs: req_ready = 00, rsp_valid = 00, rsp_result = 0, rsp_exception = 0, rsp_timeout = 0, md_operandA/B = 0, md_ctrl_* = 0, busy = 0.
- Reset during START, WAIT or RESP abandons the operation with no response. The next grant starts a fresh `multdiv` operation; any stale RDY is masked by the START rule.
- Accept edge (cycle 0) → ctrl pulse in cycle 1 → earliest RDY sample in cycle 2 → rsp_valid from the cycle after RDY.
- Timeout: rsp_valid is asserted TIMEOUT+2 cycles after the accept edge.
- Response consumed in cycle n → IDLE in n+1 → next accept no earlier than n+1. There is always at least one IDLE cycle between operations.
- rsp_valid and the response data stay stable until consumed.

## Test plan
- Mult on port 0, A=3, B=7, no contention → exactly one md_ctrl_MULT pulse in the cycle after accept; rsp_valid = 01; rsp_result = 21; rsp_exception = 0; rsp_timeout = 0.
- Both ports valid in the first cycle after reset (port0 mult 6×5, port1 div 100/7) → port 0 granted first with result 30; then port 1 with result 14; exactly one ctrl pulse each.
- Both ports requesting continuously for 4 operations → grants alternate 0, 1, 0, 1.
- Div on port 1, A=5, B=0 → md_ctrl_DIV pulse; rsp_exception = 1 (from `multdiv`); rsp_timeout = 0.
- Stub `multdiv` with RDY tied low, TIMEOUT = 8 → rsp_valid exactly 10 cycles after accept; result = 0; exc = 1; tmo = 1.
- Hold rsp_ready low for 5 cycles → response stays stable and no new grant occurs. Assert reset_n low during WAIT → every output is 0 immediately. The following request completes correctly.

Source files
------------

// File: rtl/multdiv_arbiter.sv
// multdiv_arbiter: round-robin two-port scheduler in front of a shared multdiv unit.
// Latches the winner's operands, pulses one ctrl line, and returns the result under a watchdog.
module multdiv_arbiter #(
  parameter int TIMEOUT = 64
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_a0,
  input  logic [31:0] req_b0,
  input  logic [31:0] req_a1,
  input  logic [31:0] req_b1,
  output logic [1:0]  rsp_valid,
  input  logic [1:0]  rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_exception,
  output logic        rsp_timeout,
  output logic [31:0] md_operandA,
  output logic [31:0] md_operandB,
  output logic        md_ctrl_MULT,
  output logic        md_ctrl_DIV,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  input  logic        md_resultRDY,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;
  state_t      r_state;
  logic        r_owner, r_op, r_rr, r_exc, r_tmo;
  logic [31:0] r_opa, r_opb, r_result;
  logic [7:0]  r_wdog;
  logic        w_any, w_win;
  assign w_any = |req_valid;
  assign w_win = (&req_valid) ? r_rr : req_valid[1];
  // Grant is combinational; gated by reset so a held request shows no ready while in reset.
  assign req_ready     = (reset_n && r_state == IDLE && w_any) ? (w_win ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_valid     = (r_state == RESP) ? (r_owner ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_result    = r_result;
  assign rsp_exception = r_exc;
  assign rsp_timeout   = r_tmo;
  assign md_operandA   = r_opa;
  assign md_operandB   = r_opb;
  assign md_ctrl_MULT  = (r_state == START) && !r_op;
  assign md_ctrl_DIV   = (r_state == START) && r_op;
  assign busy          = (r_state != IDLE);
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_owner  <= 1'b0;
      r_op     <= 1'b0;
      r_rr     <= 1'b0;
      r_exc    <= 1'b0;
      r_tmo    <= 1'b0;
      r_opa    <= '0;
      r_opb    <= '0;
      r_result <= '0;
      r_wdog   <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_any) begin
          r_owner <= w_win;
          r_op    <= req_op[w_win];
          r_opa   <= w_win ? req_a1 : req_a0;
          r_opb   <= w_win ? req_b1 : req_b0;
          r_state <= START;
        end
        START: begin
          r_wdog  <= '0;
          r_state <= WAIT;
        end
        WAIT: if (md_resultRDY) begin
          r_result <= md_result;
          r_exc    <= md_exception;
          r_tmo    <= 1'b0;
          r_state  <= RESP;
        end else if (r_wdog == 8'(TIMEOUT - 1)) begin
          r_result <= '0;
          r_exc    <= 1'b1;
          r_tmo    <= 1'b1;
          r_state  <= RESP;
        end else begin
          r_wdog <= r_wdog + 8'd1;
        end
        RESP: if (rsp_ready[r_owner]) begin
          r_rr    <= !r_owner;
          r_state <= IDLE;
        end
      endcase
    end
  end
endmodule
